// File: rtl/imm_scatter_encoder_if.sv
// Request/response bundle for the immediate scatter encoder.
// The encoder takes the slave side. A loader or stimulus generator takes the master side.
interface imm_scatter_encoder_if;
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         in_fmt;
   logic [6:0]         in_opcode;
   logic [4:0]         in_rd;
   logic [2:0]         in_funct3;
   logic [4:0]         in_rs1;
   logic [4:0]         in_rs2;
   logic signed [31:0] in_imm;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_instr;
   logic [2:0]         out_err;

   modport master (
      output in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_err
   );
endinterface

// File: rtl/imm_scatter_encoder.sv
// Scatters a signed immediate into the RISC-V I/S/B/U/J layout.
// Stage p1 registers the fields and range-checks them. Stage p2 assembles the word.
module imm_scatter_encoder #(
   parameter int ERRCNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   imm_scatter_encoder_if.slave bus,
   output logic [ERRCNT_W-1:0] err_cnt
);

   localparam logic [2:0] FMT_I = 3'd0;
   localparam logic [2:0] FMT_S = 3'd1;
   localparam logic [2:0] FMT_B = 3'd2;
   localparam logic [2:0] FMT_U = 3'd3;
   localparam logic [2:0] FMT_J = 3'd4;

   // Flags are {fmt_illegal, misaligned, out_of_range}.
   function automatic logic [2:0] check_imm(input logic [2:0] fmt, input logic signed [31:0] imm);
      logic [2:0] flags;
      flags = 3'b000;
      case (fmt)
         FMT_I, FMT_S: flags[0] = (imm < -32'sd2048) || (imm > 32'sd2047);
         FMT_B: begin
            flags[0] = (imm < -32'sd4096) || (imm > 32'sd4094);
            flags[1] = imm[0];
         end
         FMT_J: begin
            flags[0] = (imm < -32'sd1048576) || (imm > 32'sd1048574);
            flags[1] = imm[0];
         end
         FMT_U:   flags[0] = (imm[11:0] != 12'd0);
         default: flags[2] = 1'b1;
      endcase
      return flags;
   endfunction

   function automatic logic [31:0] scatter(
      input logic [2:0] fmt, input logic [6:0] opcode, input logic [4:0] rd,
      input logic [2:0] funct3, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic signed [31:0] imm
   );
      case (fmt)
         FMT_I:   return {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S:   return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B:   return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U:   return {imm[31:12], rd, opcode};
         FMT_J:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + {{(ERRCNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic               vld_p1, vld_p2;
   logic               adv_p1, adv_p2;
   logic [2:0]         fmt_p1;
   logic [6:0]         opcode_p1;
   logic [4:0]         rd_p1, rs1_p1, rs2_p1;
   logic [2:0]         funct3_p1;
   logic signed [31:0] imm_p1;
   logic [2:0]         err_p1;
   logic [31:0]        instr_p2;
   logic [2:0]         err_p2;

   assign adv_p2       = !vld_p2 || bus.out_ready;
   assign adv_p1       = !vld_p1 || adv_p2;
   assign bus.in_ready = adv_p1;

   // ---- stage p1: capture request and flag range errors ----
   always_ff @(posedge clk) begin
      if (reset) vld_p1 <= 1'b0;
      else if (adv_p1) vld_p1 <= bus.in_valid;
   end

   always_ff @(posedge clk) begin
      if (adv_p1 && bus.in_valid) begin
         fmt_p1    <= bus.in_fmt;
         opcode_p1 <= bus.in_opcode;
         rd_p1     <= bus.in_rd;
         funct3_p1 <= bus.in_funct3;
         rs1_p1    <= bus.in_rs1;
         rs2_p1    <= bus.in_rs2;
         imm_p1    <= bus.in_imm;
         err_p1    <= check_imm(bus.in_fmt, bus.in_imm);
      end
   end

   // ---- stage p2: assemble the instruction word ----
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p2   <= 1'b0;
         instr_p2 <= 32'h0000_0000;
         err_p2   <= 3'b000;
      end else if (adv_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            instr_p2 <= scatter(fmt_p1, opcode_p1, rd_p1, funct3_p1, rs1_p1, rs2_p1, imm_p1);
            err_p2   <= err_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) err_cnt <= '0;
      else if (vld_p2 && bus.out_ready && (err_p2 != 3'b000)) err_cnt <= sat_inc(err_cnt);
   end

   assign bus.out_valid = vld_p2;
   assign bus.out_instr = instr_p2;
   assign bus.out_err   = err_p2;

endmodule
